// File: rtl/pal576i_timing_if.sv
// Video timing bus between the PAL 576i timing generator and its consumers.
// master: timing generator (drives raster position and syncs, samples pixelCe).
// slave : pixel source / DAC side (drives pixelCe, observes the timing outputs).
interface pal576i_timing_if;
    logic       pixelCe;
    logic [9:0] pixelX;
    logic [9:0] pixelY;
    logic       displayEnable;
    logic       field;
    logic       nHsync;
    logic       nVsync;
    logic       nCsync;
    logic       frameStart;

    modport master (
        input  pixelCe,
        output pixelX, pixelY, displayEnable, field,
        output nHsync, nVsync, nCsync, frameStart
    );

    modport slave (
        output pixelCe,
        input  pixelX, pixelY, displayEnable, field,
        input  nHsync, nVsync, nCsync, frameStart
    );
endinterface

// File: rtl/pal576i_timing.sv
// PAL 625-line 50 Hz interlaced raster timing generator at the 13.5 MHz sample rate.
// Latency: every output is a registered decode of (hCount, lineNum) one pixelCe behind the counters.
// Backpressure: none; pixelCe low freezes counters and outputs. Ports: clk, nReset, bus (master).
module pal576i_timing #(
    parameter int H_TOTAL        = 864,
    parameter int H_SYNC         = 63,
    parameter int H_ACTIVE_START = 132,
    parameter int H_ACTIVE       = 720,
    parameter int EQ_WIDTH       = 32,
    parameter int BROAD_WIDTH    = 368,
    parameter int V_ACTIVE       = 288
) (
    input  logic               clk,
    input  logic               nReset,
    pal576i_timing_if.master   bus
);
    localparam int HALF      = H_TOTAL / 2;
    localparam int F1_FIRST  = 23;
    localparam int F2_FIRST  = 336;
    localparam int LINES     = 625;

    typedef enum logic [1:0] {P_NONE, P_NORMAL, P_EQ, P_BROAD} pulse_t;

    logic [9:0] h_count;
    logic [9:0] line_num;

    // Sync pulse carried by one half-line of the vertical-interval pattern.
    function automatic pulse_t pulse_for(input logic [9:0] ln, input logic hb);
        pulse_t p;
        if (ln <= 10'd2)        p = P_BROAD;
        else if (ln == 10'd3)   p = hb ? P_EQ : P_BROAD;
        else if (ln <= 10'd5)   p = P_EQ;
        else if (ln <= 10'd310) p = hb ? P_NONE : P_NORMAL;
        else if (ln <= 10'd312) p = P_EQ;
        else if (ln == 10'd313) p = hb ? P_BROAD : P_EQ;
        else if (ln <= 10'd315) p = P_BROAD;
        else if (ln <= 10'd317) p = P_EQ;
        else if (ln == 10'd318) p = hb ? P_NONE : P_EQ;
        else if (ln <= 10'd622) p = hb ? P_NONE : P_NORMAL;
        else if (ln == 10'd623) p = hb ? P_EQ : P_NORMAL;
        else                    p = P_EQ;
        return p;
    endfunction

    logic       half_b;
    logic [9:0] h_off;
    pulse_t     pulse;
    logic       f1_line, f2_line, h_act, de;
    logic       csync_low, vsync_low;
    logic [9:0] x_dec, y_dec;

    always_comb begin
        half_b  = (h_count >= 10'(HALF));
        h_off   = half_b ? (h_count - 10'(HALF)) : h_count;
        pulse   = pulse_for(line_num, half_b);

        f1_line = (line_num >= 10'(F1_FIRST)) && (line_num < 10'(F1_FIRST + V_ACTIVE));
        f2_line = (line_num >= 10'(F2_FIRST)) && (line_num < 10'(F2_FIRST + V_ACTIVE));
        h_act   = (h_count >= 10'(H_ACTIVE_START)) &&
                  (h_count <  10'(H_ACTIVE_START + H_ACTIVE));
        de      = (f1_line || f2_line) && h_act;

        x_dec   = de ? (h_count - 10'(H_ACTIVE_START)) : 10'd0;
        y_dec   = 10'd0;
        if (de)
            y_dec = f1_line ? (line_num - 10'(F1_FIRST)) : (line_num - 10'(F2_FIRST));

        case (pulse)
            P_BROAD:  csync_low = (h_off < 10'(BROAD_WIDTH));
            P_EQ:     csync_low = (h_off < 10'(EQ_WIDTH));
            P_NORMAL: csync_low = (h_off < 10'(H_SYNC));
            default:  csync_low = 1'b0;
        endcase

        // Field 1 vsync starts on a line boundary, field 2 vsync starts mid-line.
        vsync_low = (line_num == 10'd1) || (line_num == 10'd2) ||
                    ((line_num == 10'd3) && !half_b) ||
                    ((line_num == 10'd313) && half_b) ||
                    (line_num == 10'd314) || (line_num == 10'd315);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            h_count           <= 10'd0;
            line_num          <= 10'd1;
            bus.pixelX        <= 10'd0;
            bus.pixelY        <= 10'd0;
            bus.displayEnable <= 1'b0;
            bus.field         <= 1'b0;
            bus.nHsync        <= 1'b1;
            bus.nVsync        <= 1'b1;
            bus.nCsync        <= 1'b1;
            bus.frameStart    <= 1'b0;
        end else if (bus.pixelCe) begin
            bus.pixelX        <= x_dec;
            bus.pixelY        <= y_dec;
            bus.displayEnable <= de;
            bus.field         <= (line_num >= 10'd313);
            bus.nHsync        <= !(h_count < 10'(H_SYNC));
            bus.nVsync        <= !vsync_low;
            bus.nCsync        <= !csync_low;
            bus.frameStart    <= (h_count == 10'd0) && (line_num == 10'd1);

            // Comparisons use >= so a corrupted counter recovers on the next wrap.
            if (h_count >= 10'(H_TOTAL - 1)) begin
                h_count  <= 10'd0;
                if ((line_num >= 10'(LINES)) || (line_num == 10'd0))
                    line_num <= 10'd1;
                else
                    line_num <= line_num + 10'd1;
            end else begin
                h_count <= h_count + 10'd1;
            end
        end
    end
endmodule

// File: doc/pal576i_timing.md
Name: pal576i_timing

Overview:
- Generates PAL 625-line, 50 Hz interlaced (576i) raster timing at the BT.601 13.5 MHz pixel rate.
- Sits directly upstream of the RGB111 test-card/pixel source. It drives pixelX, pixelY and displayEnable into that source, and drives the sync outputs to the video DAC/SCART stage.
- Contains the horizontal sample counter, the 625-line counter, field tracking and composite-sync pattern generation.

Parameters:
- H_TOTAL, 864, pixel clocks per line (64 µs).
- H_SYNC, 63, hsync low width in pixels (4.7 µs).
- H_ACTIVE_START, 132, hCount of first active pixel.
- H_ACTIVE, 720, active pixels per line.
- EQ_WIDTH, 32, equalising pulse low width (2.35 µs).
- BROAD_WIDTH, 368, broad pulse low width (27.3 µs).
- V_ACTIVE, 288, active lines per field.

Ports:
- clk  in  1  system clock.
- nReset  in  1  reset.
- pixelCe  in  1  pixel clock enable; tie to 1 when clk is 13.5 MHz.
- pixelX  out  10  active pixel index 0..719; 0 outside the active area.
- pixelY  out  10  active line within field 0..287; 0 outside the active area.
- displayEnable  out  1  high during active pixels of active lines.
- field  out  1  0 = field 1 (lines 1-312), 1 = field 2 (lines 313-625).
- nHsync  out  1  horizontal sync, active low.
- nVsync  out  1  vertical sync, active low.
- nCsync  out  1  composite sync with equalising and broad pulses, active low.
- frameStart  out  1  one-pixelCe-period pulse at line 1, hCount 0.

Behaviour:
- Reset: nReset is asynchronous, active-low; clock is clk. While nReset is low:
  - hCount=0, lineNum=1.
  - All outputs: pixelX=0, pixelY=0, displayEnable=0, field=0, nHsync=1, nVsync=1, nCsync=1, frameStart=0.
  - Assertion mid-frame returns immediately to these values. After release, the first pixelCe decodes (0, line 1).
- Counter advance: all state advances only on clk edges with pixelCe=1; with pixelCe=0 everything holds.
  - hCount runs 0..H_TOTAL-1, then wraps to 0 and increments lineNum.
  - lineNum runs 1..625, then wraps to 1.
  - hCount 0 is the leading edge of line sync.
- Output latency: outputs are registered decodes of the pre-advance (hCount, lineNum), so they lag the counters by exactly one pixelCe.
  - No combinational path from input to output.
- Active lines: lines 23..310 (field 1) and 336..623 (field 2); each field has V_ACTIVE lines.
- displayEnable = active line AND H_ACTIVE_START <= hCount < H_ACTIVE_START+H_ACTIVE.
- pixelX = hCount-H_ACTIVE_START and pixelY = lineNum-23 (field 1) or lineNum-336 (field 2) when displayEnable is high; both are 0 otherwise.
- field = (lineNum >= 313).
- nHsync: low for hCount < H_SYNC on every line, including vertical-interval lines.
- nVsync: low from (line 1, h 0) through (line 3, h 431), and from (line 313, h 432) through (line 315, h 863).
- nCsync, evaluated per half-line: half A is h 0..431, half B is h 432..863. Each half carries one pulse starting at its half start.
  - Broad (B): low for BROAD_WIDTH.
  - Equalising (E): low for EQ_WIDTH.
  - Normal (N): line sync low for H_SYNC in half A only; half B stays high.
  - None (-): high throughout.
- nCsync pattern (A/B per line):
  - Lines 1-2: B/B.
  - Line 3: B/E.
  - Lines 4-5: E/E.
  - Lines 6-310: N.
  - Lines 311-312: E/E.
  - Line 313: E/B.
  - Lines 314-315: B/B.
  - Lines 316-317: E/E.
  - Line 318: E/-.
  - Lines 319-622: N.
  - Line 623: N/E.
  - Lines 624-625: E/E.
- frameStart: high for the single pixelCe period that decodes (h 0, line 1); otherwise low.
- Counter widths: hCount 10 bits, lineNum 10 bits. Out-of-range states are unreachable; if forced, they wrap to 0 / 1 on the next advance.

Test Plan:
- Reset then 2 full frames with pixelCe=1 -> exactly 864×625 clocks between frameStart pulses; frameStart high for 1 clock.
- Line 23 -> displayEnable rises on the output cycle for hCount 132 with pixelX=0, pixelY=0; falls after pixelX=719; exactly 720 high cycles per active line.
- Count displayEnable lines per field -> 288 in field 1 (pixelY 0..287) and 288 in field 2 (line 336 gives pixelY=0, field=1); displayEnable is 0 on lines 311, 624 and 625.
- Sample nCsync on lines 1, 3, 5, 313, 318 and 623 -> low-pulse widths/positions match the pattern (e.g. line 3: 368 low at h0, 32 low at h432; line 318: 32 low at h0 only).
- Drive pixelCe=1 every 2nd clk -> all outputs change only on ce cycles and the frame period is 2×540000 clocks.
- Assert nReset at line 400, h 500 -> all outputs reach reset values asynchronously; after release, the first decoded state is h0/line1 with nHsync=0, nCsync=0 and frameStart=1.
